iter_shifter: RTL and testbench
===============================

// Module: iter_shifter
// PURPOSE
//  Multi-cycle, parametrised shifter unit for the 16-bit datapath. Generalises the
//  fixed left-shift-by-4 helper to any shift amount, direction and fill mode.
//  Shifts STEP bits per cycle under a valid/ready handshake.
//  Sits beside the ALU and serves shift-class instructions.
// PARAMETERS
//  WIDTH  16  data width in bits (>=4)
//  STEP   4   max bits shifted per cycle (1..WIDTH, power of two)
//  AMT_W  5   shift-amount width; must satisfy 2**AMT_W > WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation request
//  in_ready   out  1      unit can accept a request (high only in IDLE)
//  in_data    in   WIDTH  operand
//  in_amt     in   AMT_W  shift amount
//  in_mode    in   2      00 SLL, 01 SRL, 10 SRA, 11 ROL (ROL only with SHIFT_ROTATE_EN)
//  out_valid  out  1      result available
//  out_ready  in   1      consumer accepts result
//  out_data   out  WIDTH  result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_data=0, internal regs=0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE : in_ready=1. On in_valid, capture data/amt/mode.
//          amt==0 -> DONE next cycle with out_data=in_data; otherwise -> SHIFT.
//   SHIFT: each cycle shift by min(STEP, remaining) and decrement remaining;
//          at remaining==0 -> DONE. in_ready=0.
//   DONE : out_valid=1; out_data held stable until out_valid&&out_ready,
//          then -> IDLE. No new request is accepted in the handshake cycle.
//  Latency: ceil(amt_eff/STEP)+1 cycles from accept to out_valid (amt 0 -> 1 cycle).
//  Amount clamp: SLL/SRL with amt>=WIDTH -> result 0 in one SHIFT cycle.
//   SRA with amt>=WIDTH -> all bits = captured in_data[WIDTH-1].
//   ROL: amt_eff = amt mod WIDTH.
//  Fill: SLL zero-fills LSBs; SRL zero-fills MSBs; SRA replicates the original sign bit.
//  Inputs are ignored while in_ready=0; in_data changing during SHIFT has no effect.
//  rst_n asserted mid-operation aborts immediately to reset values; no partial result.
//  Undefined in_mode 11 without SHIFT_ROTATE_EN: treated as SLL.
// CONFIGURATION
//  SHIFT_ROTATE_EN defined: mode 11 = rotate left; bits shifted out of the MSB
//   re-enter at the LSB; amt taken mod WIDTH.
//  SHIFT_ROTATE_EN undefined: no rotate logic; mode 11 behaves exactly as SLL.
// STRUCTURE
//  Package shifter_pkg: mode localparams (MODE_SLL/SRL/SRA/ROL), FSM state
//   encoding (ST_IDLE/ST_SHIFT/ST_DONE).
//  Sub-module shift_stage: combinational one-step shifter (data, k<=STEP, mode,
//   sign) -> shifted data; iter_shifter holds the FSM, counters and registers.
// TESTING
//  SLL 16'h0001, amt 4, STEP 4 -> out_data 16'h0010, out_valid 2 cycles after accept.
//  SRA 16'h8000, amt 15 -> 16'hFFFF after 5 cycles; SRL same input -> 16'h0001.
//  amt 0, data 16'hBEEF -> 16'hBEEF after 1 cycle; amt 20 SRL -> 16'h0000.
//  out_ready held low 3 cycles in DONE -> out_data stable, in_ready=0 throughout.
//  rst_n pulsed low during SHIFT -> out_valid=0, in_ready=1 asynchronously; next op correct.
//  With SHIFT_ROTATE_EN: ROL 16'h8001, amt 17 -> 16'h0003. Without it: mode 11 -> 16'h0002.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared mode encodings and FSM state type for the iterative shifter.
package shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// Combinational single-step shifter: shifts data by k (k <= STEP) in the given mode.
// Rotate support is compiled in only when SHIFT_ROTATE_EN is defined.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 5
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] k,
  input  logic [1:0]       mode,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);

  logic [WIDTH-1:0] hi_mask;

  // Mode-dependent shift; SRA fills the vacated MSBs with the captured sign
  always_comb begin
    hi_mask = ~({WIDTH{1'b1}} >> k);
    result  = data << k;
    case (mode)
      MODE_SRL: result = data >> k;
      MODE_SRA: result = (data >> k) | (hi_mask & {WIDTH{sign}});
`ifdef SHIFT_ROTATE_EN
      MODE_ROL: result = (data << k) | (data >> (WIDTH_A - k));
`endif
      default:  result = data << k;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: shifts up to STEP bits per cycle under valid/ready handshakes.
// Optional feature: define SHIFT_ROTATE_EN to enable mode 11 as rotate-left;
// otherwise mode 11 behaves exactly as SLL.
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 4,
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] STEP_A  = AMT_W'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] rem_q;
  logic [1:0]       mode_q;
  logic             sign_q;
  logic             clamp_q;
  logic             in_ready_d, out_valid_d;

  logic [1:0]       cap_mode;
  logic [AMT_W-1:0] cap_amt;
  logic             cap_clamp;
  logic [AMT_W-1:0] step_k;
  logic [AMT_W-1:0] rem_next;
  logic [WIDTH-1:0] stage_out;

  // Request decode: effective mode, effective amount and out-of-range clamp
  always_comb begin
    cap_mode  = in_mode;
    cap_amt   = in_amt;
    cap_clamp = 1'b0;
`ifdef SHIFT_ROTATE_EN
    if (in_mode == MODE_ROL) begin
      cap_amt = in_amt % WIDTH_A;
    end else if (in_amt >= WIDTH_A) begin
      cap_clamp = 1'b1;
    end
`else
    if (in_mode == MODE_ROL) begin
      cap_mode = MODE_SLL;
    end
    if (in_amt >= WIDTH_A) begin
      cap_clamp = 1'b1;
    end
`endif
  end

  // Per-cycle step size and remaining amount after this step
  always_comb begin
    step_k   = (rem_q > STEP_A) ? STEP_A : rem_q;
    rem_next = rem_q - step_k;
  end

  shift_stage #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_stage (
    .data   (data_q),
    .k      (step_k),
    .mode   (mode_q),
    .sign   (sign_q),
    .result (stage_out)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = (cap_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (clamp_q || (rem_next == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they register with it
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_d == ST_IDLE) in_ready_d  = 1'b1;
    if (state_d == ST_DONE) out_valid_d = 1'b1;
  end

  // Registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Datapath: capture on accept, iterate while shifting, hold in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_SLL;
      sign_q  <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            rem_q   <= cap_amt;
            mode_q  <= cap_mode;
            sign_q  <= in_data[WIDTH-1];
            clamp_q <= cap_clamp;
          end
        end
        ST_SHIFT: begin
          if (clamp_q) begin
            data_q <= (mode_q == MODE_SRA) ? {WIDTH{sign_q}} : '0;
            rem_q  <= '0;
          end else begin
            data_q <= stage_out;
            rem_q  <= rem_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter (WIDTH 16, STEP 4, AMT_W 5).
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int checks   = 0;
  int failures = 0;

  iter_shifter #(.WIDTH(16), .STEP(4), .AMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, verify latency and result, optionally stall in DONE
  task automatic run_op(input string tag, input logic [15:0] d, input logic [4:0] a,
                        input logic [1:0] m, input logic [15:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'h5A5A;
    in_amt   = 5'd3;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_data"}, 32'(out_data), 32'(exp));
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_amt    = 5'd0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("sll4",    16'h0001, 5'd4,  2'b00, 16'h0010, 2, 0);
    run_op("sra15",   16'h8000, 5'd15, 2'b10, 16'hFFFF, 5, 0);
    run_op("srl15",   16'h8000, 5'd15, 2'b01, 16'h0001, 5, 0);
    run_op("amt0",    16'hBEEF, 5'd0,  2'b01, 16'hBEEF, 1, 0);
    run_op("srl20",   16'hA5A5, 5'd20, 2'b01, 16'h0000, 2, 0);
    run_op("sra20n",  16'h8000, 5'd20, 2'b10, 16'hFFFF, 2, 0);
    run_op("sra20p",  16'h7FFF, 5'd20, 2'b10, 16'h0000, 2, 0);
    run_op("sll7",    16'h1234, 5'd7,  2'b00, 16'h1A00, 3, 0);
    run_op("sra6",    16'h8421, 5'd6,  2'b10, 16'hFE10, 3, 0);
    run_op("sll16",   16'hFFFF, 5'd16, 2'b00, 16'h0000, 2, 0);
    run_op("sll15",   16'h0001, 5'd15, 2'b00, 16'h8000, 5, 0);
    run_op("stall",   16'h00F0, 5'd4,  2'b01, 16'h000F, 2, 3);
`ifdef SHIFT_ROTATE_EN
    run_op("rol17",   16'h8001, 5'd17, 2'b11, 16'h0003, 2, 0);
    run_op("rol16",   16'h8001, 5'd16, 2'b11, 16'h8001, 1, 0);
    run_op("rol5",    16'hF00F, 5'd5,  2'b11, 16'h01FE, 3, 0);
`else
    run_op("mode11",  16'h8001, 5'd1,  2'b11, 16'h0002, 2, 0);
    run_op("mode11b", 16'h8001, 5'd17, 2'b11, 16'h0000, 2, 0);
`endif

    // Abort mid-SHIFT with an asynchronous reset
    in_valid = 1'b1;
    in_data  = 16'h8000;
    in_amt   = 5'd15;
    in_mode  = 2'b10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 16'h0F00, 5'd8, 2'b01, 16'h000F, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
